// File: rtl/audio_pkg.sv
// Shared types and defaults for the codec-side audio sequencing logic.
package audio_pkg;
  localparam int AUDIO_DW        = 24;
  localparam int DEFAULT_TIMEOUT = 1000;
  localparam int DEFAULT_TW      = 10;

  typedef enum logic [2:0] {
    IDLE,
    START_L,
    WAIT_L,
    START_R,
    WAIT_R,
    COMMIT
  } seq_state_t;
endpackage

// File: rtl/seq_timeout_timer.sv
// Saturating wait-cycle counter; expired flags the last allowed cycle of a wait.
module seq_timeout_timer
  import audio_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int TW      = DEFAULT_TW
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic run,
  output logic expired
);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (run && (r_count != LAST)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = (r_count == LAST);
endmodule

// File: rtl/filter_channel_sequencer.sv
// Time-shares one single-channel filter core between L and R, committing both
// results as an aligned pair; supports bypass, per-channel timeout and overrun.
module filter_channel_sequencer
  import audio_pkg::*;
#(
  parameter int DW      = AUDIO_DW,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int TW      = DEFAULT_TW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  input  logic          sample_ready,
  input  logic [DW-1:0] l_in,
  input  logic [DW-1:0] r_in,
  output logic          flt_start,
  output logic [DW-1:0] flt_din,
  input  logic [DW-1:0] flt_dout,
  input  logic          flt_done,
  output logic [DW-1:0] l_out,
  output logic [DW-1:0] r_out,
  output logic          out_valid,
  output logic          busy,
  output logic          overrun,
  output logic          timeout
);
  seq_state_t r_state, w_next;

  logic [DW-1:0] r_l_lat, r_r_lat;
  logic [DW-1:0] r_l_res, r_r_res;
  logic [DW-1:0] r_flt_din;
  logic [DW-1:0] r_l_out, r_r_out;

  logic w_expired;
  logic w_start;
  logic w_wait;
  logic w_wait_exit;

  seq_timeout_timer #(
    .TIMEOUT(TIMEOUT),
    .TW     (TW)
  ) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (w_start),
    .run    (w_wait),
    .expired(w_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_start     = 1'b0;
    w_wait      = 1'b0;
    w_wait_exit = 1'b0;
    case (r_state)
      IDLE: begin
        if (sample_ready) w_next = enable ? START_L : COMMIT;
      end
      START_L: begin
        w_start = 1'b1;
        w_next  = WAIT_L;
      end
      WAIT_L: begin
        w_wait      = 1'b1;
        w_wait_exit = flt_done || w_expired;
        if (w_wait_exit) w_next = START_R;
      end
      START_R: begin
        w_start = 1'b1;
        w_next  = WAIT_R;
      end
      WAIT_R: begin
        w_wait      = 1'b1;
        w_wait_exit = flt_done || w_expired;
        if (w_wait_exit) w_next = COMMIT;
      end
      COMMIT: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // A completion in the expiry cycle takes priority, so no fallback is flagged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_l_lat   <= '0;
      r_r_lat   <= '0;
      r_l_res   <= '0;
      r_r_res   <= '0;
      r_flt_din <= '0;
      r_l_out   <= '0;
      r_r_out   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (sample_ready) begin
            r_l_lat <= l_in;
            r_r_lat <= r_in;
            if (enable) begin
              r_flt_din <= l_in;
            end else begin
              r_l_res <= l_in;
              r_r_res <= r_in;
            end
          end
        end
        WAIT_L: begin
          if (w_wait_exit) begin
            r_l_res   <= flt_done ? flt_dout : r_l_lat;
            r_flt_din <= r_r_lat;
          end
        end
        WAIT_R: begin
          if (w_wait_exit) r_r_res <= flt_done ? flt_dout : r_r_lat;
        end
        COMMIT: begin
          r_l_out <= r_l_res;
          r_r_out <= r_r_res;
        end
        default: ;
      endcase
    end
  end

  assign flt_start = (r_state == START_L) || (r_state == START_R);
  assign flt_din   = r_flt_din;
  assign l_out     = r_l_out;
  assign r_out     = r_r_out;
  assign out_valid = (r_state == COMMIT);
  assign busy      = (r_state != IDLE);
  assign overrun   = sample_ready && busy;
  assign timeout   = w_wait && w_expired && !flt_done;
endmodule
